// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants for the calculator display back-end
package disp_pkg;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    localparam int FINISH   = 7;
    localparam int STATE_HI = 6;
    localparam int STATE_LO = 5;
    localparam int NDIG     = 5;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = SEG_0;
            4'd1:    seg_code = SEG_1;
            4'd2:    seg_code = SEG_2;
            4'd3:    seg_code = SEG_3;
            4'd4:    seg_code = SEG_4;
            4'd5:    seg_code = SEG_5;
            4'd6:    seg_code = SEG_6;
            4'd7:    seg_code = SEG_7;
            4'd8:    seg_code = SEG_8;
            4'd9:    seg_code = SEG_9;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd16.sv
// rtl/bin2bcd16.sv - sequential 16-bit double-dabble converter, one bit per cycle
module bin2bcd16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    logic [15:0] sh;
    logic [19:0] acc;
    logic [19:0] adj;
    logic [3:0]  cnt;

    always_comb begin
        adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // bcd is the post-iteration value, so it is complete in the same cycle done is high
    assign bcd  = {adj[18:0], sh[15]};
    assign done = busy && (cnt == 4'd15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (busy) begin
            acc <= bcd;
            sh  <= {sh[14:0], 1'b0};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15)
                busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            sh   <= bin;
            acc  <= '0;
            cnt  <= '0;
        end
    end

endmodule

// File: rtl/disp_out.sv
// rtl/disp_out.sv - value select, BCD conversion and multiplexed 7-segment drive
module disp_out
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        IN_clk,
    input  logic        IN_reset,
    input  logic        IN_valid,
    input  logic [7:0]  IN_SRCH,
    input  logic [7:0]  IN_SRCL,
    input  logic [7:0]  IN_DSTH,
    input  logic [7:0]  IN_DSTL,
    input  logic [7:0]  IN_ctrl,
    input  logic [15:0] IN_RES,
    output logic [7:0]  OUT_seg,
    output logic [4:0]  OUT_dig,
    output logic        OUT_busy
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [15:0]               sel_val;
    logic [15:0]               last_val;
    logic                      sel_dp;
    logic                      conv_dp;
    logic                      disp_dp;
    logic [NDIG-1:0][3:0]      bank;
    logic [19:0]               bcd;
    logic                      done;
    logic                      start;
    logic [PW-1:0]             presc;
    logic [2:0]                idx;
    logic [NDIG-1:0]           nz;
    logic                      any;
    logic [7:0]                seg;
    logic                      unused_ctrl;

    assign unused_ctrl = ^IN_ctrl[4:0];

    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            sel_val <= '0;
            sel_dp  <= 1'b0;
        end else if (IN_valid) begin
            case (IN_ctrl[STATE_HI:STATE_LO])
                S0: begin sel_val <= '0;                 sel_dp <= 1'b0; end
                S1: begin sel_val <= {IN_SRCH, IN_SRCL}; sel_dp <= 1'b0; end
                S2: begin
                    if (IN_ctrl[FINISH]) begin
                        sel_val <= IN_RES;
                        sel_dp  <= 1'b1;
                    end else begin
                        sel_val <= {IN_SRCH, IN_SRCL};
                        sel_dp  <= 1'b0;
                    end
                end
                default: begin sel_val <= {IN_DSTH, IN_DSTL}; sel_dp <= 1'b0; end
            endcase
        end
    end

    // A change seen mid-conversion is picked up once the converter goes idle
    assign start = !OUT_busy && (sel_val != last_val);

    bin2bcd16 u_conv (
        .clk   (IN_clk),
        .reset (IN_reset),
        .start (start),
        .bin   (sel_val),
        .busy  (OUT_busy),
        .done  (done),
        .bcd   (bcd)
    );

    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            last_val <= '0;
            conv_dp  <= 1'b0;
            disp_dp  <= 1'b0;
            bank     <= '0;
        end else begin
            if (start) begin
                last_val <= sel_val;
                conv_dp  <= sel_dp;
            end
            if (done) begin
                bank    <= bcd;
                disp_dp <= conv_dp;
            end
        end
    end

    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 3'(NDIG - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // nz[i]: digit i or some higher digit is non-zero
    always_comb begin
        any = 1'b0;
        nz  = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            any   = any | (bank[i] != 4'd0);
            nz[i] = any;
        end
    end

    always_comb begin
        if (idx != 3'd0 && !nz[idx])
            seg = SEG_BLANK;
        else
            seg = seg_code(bank[idx]);
        if (idx == 3'd0 && disp_dp)
            seg[7] = 1'b0;
    end

    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            OUT_seg <= SEG_BLANK;
            OUT_dig <= 5'h1F;
        end else begin
            OUT_seg <= seg;
            OUT_dig <= ~(5'd1 << idx);
        end
    end

endmodule

// File: tb/tb_disp_out.sv
// tb/tb_disp_out.sv - randomized self-checking bench for disp_out against a decimal display model
module tb_disp_out;

    logic        IN_clk = 1'b0;
    logic        IN_reset = 1'b0;
    logic        IN_valid = 1'b0;
    logic [7:0]  IN_SRCH = '0, IN_SRCL = '0, IN_DSTH = '0, IN_DSTL = '0, IN_ctrl = '0;
    logic [15:0] IN_RES = '0;
    logic [7:0]  OUT_seg;
    logic [4:0]  OUT_dig;
    logic        OUT_busy;

    int checks = 0;
    int failures = 0;
    int cyc;
    int pub_val = 0;
    bit pub_dp = 1'b0;
    int last_val = 0;

    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    disp_out #(.SCAN_DIV(4)) dut (
        .IN_clk  (IN_clk),
        .IN_reset(IN_reset),
        .IN_valid(IN_valid),
        .IN_SRCH (IN_SRCH),
        .IN_SRCL (IN_SRCL),
        .IN_DSTH (IN_DSTH),
        .IN_DSTL (IN_DSTL),
        .IN_ctrl (IN_ctrl),
        .IN_RES  (IN_RES),
        .OUT_seg (OUT_seg),
        .OUT_dig (OUT_dig),
        .OUT_busy(OUT_busy)
    );

    always #5 IN_clk = ~IN_clk;

    always @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int val, input bit dp, input int i);
        int p = 1;
        logic [7:0] s;
        for (int j = 0; j < i; j++) p = p * 10;
        if (i > 0 && val < p) return 8'hFF;
        s = segtab[(val / p) % 10];
        if (i == 0 && dp) s[7] = 1'b0;
        return s;
    endfunction

    // idx seen in OUT_dig after edge k of the scan is ((k-1)/4) mod 5
    task automatic show_check(input int val, input bit dp, input int n);
        int e;
        for (int c = 0; c < n; c++) begin
            e = ((cyc - 1) / 4) % 5;
            chk("dig", {27'd0, OUT_dig}, {27'd0, ~(5'd1 << e)});
            chk("seg", {24'd0, OUT_seg}, {24'd0, exp_seg(val, dp, e)});
            @(negedge IN_clk);
        end
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge IN_clk);
            ok = OUT_busy;
        end
        chk("busy_rise", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_len(output int n);
        n = 0;
        while (OUT_busy && n < 64) begin
            n++;
            @(negedge IN_clk);
        end
    endtask

    task automatic drive(input int st, input bit fin, input int src, input int dst, input int res, input bit v);
        IN_valid = v;
        IN_ctrl  = {fin, 2'(st), 5'($urandom)};
        {IN_SRCH, IN_SRCL} = 16'(src);
        {IN_DSTH, IN_DSTL} = 16'(dst);
        IN_RES   = 16'(res);
    endtask

    task automatic apply(input int st, input bit fin, input int src, input int dst, input int res);
        int ev;
        bit ed;
        bit ok;
        int n;
        ed = 1'b0;
        if (st == 0) ev = 0;
        else if (st == 1) ev = src;
        else if (st == 3) ev = dst;
        else if (fin) begin ev = res; ed = 1'b1; end
        else ev = src;
        drive(st, fin, src, dst, res, 1'b1);
        if (ev != last_val) begin
            wait_busy(ok);
            run_len(n);
            chk("busy_len", n, 16);
            last_val = ev;
            pub_val = ev;
            pub_dp = ed;
            @(negedge IN_clk);
        end else begin
            for (int c = 0; c < 20; c++) begin
                @(negedge IN_clk);
                chk("no_conv", {31'd0, OUT_busy}, 32'd0);
            end
        end
        show_check(pub_val, pub_dp, 20);
    endtask

    initial begin
        bit ok;
        int n;
        int v;
        repeat (3) @(negedge IN_clk);
        chk("rst_seg", {24'd0, OUT_seg}, 32'hFF);
        chk("rst_dig", {27'd0, OUT_dig}, 32'h1F);
        chk("rst_busy", {31'd0, OUT_busy}, 32'd0);
        IN_reset = 1'b1;
        @(negedge IN_clk);
        chk("first_dig", {27'd0, OUT_dig}, 32'h1E);
        chk("first_seg", {24'd0, OUT_seg}, 32'hC0);
        show_check(0, 1'b0, 24);
        chk("idle_busy", {31'd0, OUT_busy}, 32'd0);

        apply(1, 1'b0, 123, 0, 0);
        apply(2, 1'b1, 7, 9, 65535);

        // value change on the 5th conversion cycle
        drive(1, 1'b0, 123, 0, 0, 1'b1);
        wait_busy(ok);
        repeat (4) @(negedge IN_clk);
        IN_SRCL = 8'd45;
        IN_SRCH = 8'd0;
        run_len(n);
        chk("intr_len1", n, 12);
        n = 0;
        while (!OUT_busy && n < 10) begin
            n++;
            @(negedge IN_clk);
        end
        chk("intr_gap", n, 1);
        show_check(123, 1'b0, 15);
        run_len(n);
        chk("intr_len2", n + 15, 16);
        @(negedge IN_clk);
        show_check(45, 1'b0, 20);
        last_val = 45;
        pub_val = 45;
        pub_dp = 1'b0;

        // reset on the 8th conversion cycle
        drive(3, 1'b0, 0, 9999, 0, 1'b1);
        wait_busy(ok);
        repeat (7) @(negedge IN_clk);
        IN_reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, OUT_busy}, 32'd0);
        chk("mid_rst_dig", {27'd0, OUT_dig}, 32'h1F);
        drive(0, 1'b0, 0, 0, 0, 1'b1);
        @(negedge IN_clk);
        IN_reset = 1'b1;
        last_val = 0;
        pub_val = 0;
        pub_dp = 1'b0;
        @(negedge IN_clk);
        show_check(0, 1'b0, 20);
        chk("post_rst_busy", {31'd0, OUT_busy}, 32'd0);

        for (int it = 0; it < 14; it++) begin
            v = $urandom_range(1, 5);
            n = 1;
            for (int j = 0; j < v; j++) n = n * 10;
            if (it % 5 == 4) begin
                drive($urandom_range(0, 3), 1'($urandom), $urandom % n, $urandom, $urandom, 1'b0);
                for (int c = 0; c < 6; c++) begin
                    @(negedge IN_clk);
                    chk("invalid_busy", {31'd0, OUT_busy}, 32'd0);
                end
                show_check(pub_val, pub_dp, 20);
            end else if (it % 5 == 2) begin
                apply(1, 1'b0, last_val, 0, 0);
            end else begin
                apply($urandom_range(0, 3), 1'($urandom), ($urandom % n) & 16'hFFFF,
                      ($urandom % n) & 16'hFFFF, ($urandom % n) & 16'hFFFF);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_out.md
# disp_out

Display back-end for the keypad calculator. It samples the operand/control bus written by the keypad collector plus the ALU result, and picks the value to show from the entry state. It converts that value to BCD with a sequential double-dabble engine. It then drives a 5-digit multiplexed, active-low 7-segment display with leading-zero blanking.

## Interface
Parameters:
- SCAN_DIV, 50000: IN_clk cycles per digit scan slot; legal range 2..2^20.

Ports:
- IN_clk  in  1  system clock
- IN_reset  in  1  reset, asynchronous, active-low
- IN_valid  in  1  high when the bus is driven (writer's IN_wr); bus ignored when low
- IN_SRCH, IN_SRCL  in  8 each  first operand {H,L}
- IN_DSTH, IN_DSTL  in  8 each  second operand {H,L}
- IN_ctrl  in  8  [7]=finish, [6:5]=entry state (0..3), [4:0] ignored
- IN_RES  in  16  ALU result, unsigned
- OUT_seg  out  8  [7]=dp, [6:0]=g..a; active-low, registered
- OUT_dig  out  5  digit enable, one-hot active-low, bit0 = least-significant digit, registered
- OUT_busy  out  1  high while a BCD conversion is in progress

## Operation
- Selection, evaluated each cycle while IN_valid=1; sel_val and sel_dp are registered:
  - state 0: value 0.
  - state 1: SRC.
  - state 2 with finish=0: SRC.
  - state 3: DST.
  - state 2 with finish=1: RES, and sel_dp=1.
- While IN_valid=0, sel_val and sel_dp hold.
- Conversion start: converter idle and sel_val != last_val. On start, last_val <= sel_val and OUT_busy <= 1.
- Converter: 16-bit double-dabble, one shift/add-3 iteration per cycle, 16 iterations, producing 5 BCD digits. Each digit ≥5 gets +3 before the shift; digit 4 is at most 6.
- The digit register bank (d4..d0) and disp_dp update atomically in the cycle the last iteration completes. OUT_busy falls the same cycle.
- A value change during a conversion does not abort it. The running conversion completes and publishes. The next cycle sees sel_val != last_val and restarts.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→4→0.
  - OUT_dig = ~(1<<idx).
- Segment codes (hex, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- Leading-zero blanking: digit i (i≥1) shows blank if it and all higher digits are 0. Digit 0 is never blanked.
- dp: OUT_seg[7]=0 only on digit 0 and only when disp_dp=1.

## Timing
- Reset values:
  - OUT_seg=8'hFF, OUT_dig=5'h1F, OUT_busy=0.
  - d4..d0=0, last_val=0, sel_val=0, sel_dp=0, disp_dp=0.
  - Prescaler=0, idx=0.
- Reset mid-conversion aborts immediately with no partial publish.
- First cycle after reset release: OUT_dig=5'b11110, OUT_seg=8'hC0.
- Latency:
  - Bus change to sel_val: 1 cycle.
  - sel_val to OUT_busy high: 1 cycle.
  - Conversion to digit bank update: 16 cycles.
  - Digit bank to OUT_seg: 1 cycle, when that digit is selected.
- OUT_seg and OUT_dig change together, in the cycle after the idx update. There are no glitch cycles between them.
- A selected value equal to last_val never starts a conversion.

## Structure
- Package disp_pkg holds:
  - entry-state constants S0..S3 matching the collector encoding;
  - ctrl bit positions (FINISH=7, STATE=6:5);
  - NDIG=5;
  - SEG_0..SEG_9 and SEG_BLANK constants.
- Sub-module bin2bcd16:
  - inputs: clk, reset, start, bin[15:0];
  - outputs: busy, done (1-cycle pulse), bcd[19:0];
  - implements the sequential double-dabble engine.
- Top level holds the selection, compare/start logic, digit bank, prescaler, scan and segment decode.

## Test plan
- Reset, then release: OUT_seg=FF and OUT_dig=1F during reset; 1 cycle after release, OUT_dig=11110 and OUT_seg=C0; OUT_busy stays 0.
- IN_valid=1, state=1, SRC=16'd123: OUT_busy is high for exactly 16 cycles. Then the digits show 3/2/1 as B0/A4/F9, digits 3 and 4 read FF, and dp is off.
- state=2, finish=1, RES=16'd65535: digits 4..0 show 6,5,5,3,5 as 82/92/92/B0/92; digit 0 reads 12 (dp on).
- SRC changes from 123 to 45 at the 5th conversion cycle: 123 is published first. OUT_busy drops for exactly 1 cycle, then 45 converts and is published 17 cycles later.
- IN_reset asserted at the 8th conversion cycle: OUT_busy=0 immediately, no publish. After release, the display shows "0".
- SCAN_DIV=4: idx advances every 4 cycles. OUT_dig sequence is 11110, 11101, 11011, 10111, 01111, then 11110.
